// File: rtl/instr_loader_if.sv
// Byte-stream loader bus: host control, byte stream and instruction-memory write port.
//   Host side  : start, word_count, rx_data, rx_valid -> loader; rx_ready <- loader
//   Memory side: WE, WA, WD (word-aligned write port)
//   Status     : cpu_hold, busy, done, err, loaded_words
// master = host/CPU-side driver of requests, slave = the loader itself.
interface instr_loader_if;
    logic        start;
    logic [6:0]  word_count;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        WE;
    logic [31:0] WA;
    logic [31:0] WD;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  loaded_words;

    modport master (
        output start, word_count, rx_data, rx_valid,
        input  rx_ready, WE, WA, WD, cpu_hold, busy, done, err, loaded_words
    );

    modport slave (
        input  start, word_count, rx_data, rx_valid,
        output rx_ready, WE, WA, WD, cpu_hold, busy, done, err, loaded_words
    );
endinterface

// File: rtl/instr_loader.sv
// Instruction loader: receives a byte stream, packs it little-endian into
// 32-bit words, writes them to instruction memory from address 0 upward,
// then checks a trailing XOR checksum byte. Holds the CPU while loading.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : instr_loader_if.slave (request, byte stream, memory write, status)
// All outputs are registered; each output register is loaded from the value
// it must carry in the next state, so outputs line up with the state register.
module instr_loader #(
    parameter int unsigned DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    instr_loader_if.slave bus
);

    // word_count is 7 bits wide, so DEPTH is expected to be at most 127
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  DEPTH_L = 8'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECV   = 3'd1,
        WRITE  = 3'd2,
        CHECK  = 3'd3,
        FINISH = 3'd4
    } state_e;

    state_e             state_q,    state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [6:0]         count_q,    count_d;
    logic [7:0]         csum_q,     csum_d;
    logic [31:0]        asm_q,      asm_d;

    logic               rx_ready_q, rx_ready_d;
    logic               we_q,       we_d;
    logic [31:0]        wa_q,       wa_d;
    logic [31:0]        wd_q,       wd_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic [6:0]         loaded_q,   loaded_d;

    logic               accept_c;
    logic               count_ok_c;

    // A byte is consumed only when both sides agree in the same cycle
    assign accept_c   = bus.rx_valid && rx_ready_q;
    assign count_ok_c = (bus.word_count != 7'd0) && ({1'b0, bus.word_count} <= DEPTH_L);

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        err_d      = err_q;
        loaded_d   = loaded_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (count_ok_c) begin
                        state_d    = RECV;
                        err_d      = 1'b0;
                        loaded_d   = 7'd0;
                        byte_idx_d = 2'd0;
                        word_idx_d = '0;
                        csum_d     = 8'd0;
                        asm_d      = 32'd0;
                        count_d    = bus.word_count;
                    end else begin
                        // Bad count: report failure without touching memory
                        state_d  = FINISH;
                        err_d    = 1'b1;
                        loaded_d = 7'd0;
                    end
                end
            end

            RECV: begin
                if (accept_c) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: present it on the write port next cycle
                        state_d  = WRITE;
                        wa_d     = 32'({word_idx_q, 2'b00});
                        wd_d     = asm_d;
                        loaded_d = loaded_q + 7'd1;
                    end
                end
            end

            WRITE: begin
                // loaded_q already counts the word being written
                if (loaded_q == count_q) begin
                    state_d = CHECK;
                end else begin
                    state_d    = RECV;
                    word_idx_d = word_idx_q + IDX_W'(1);
                end
            end

            CHECK: begin
                if (accept_c) begin
                    if (bus.rx_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rx_ready_d = (state_d == RECV) || (state_d == CHECK);
        we_d       = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            word_idx_q <= '0;
            count_q    <= 7'd0;
            csum_q     <= 8'd0;
            asm_q      <= 32'd0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wa_q       <= 32'd0;
            wd_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            loaded_q   <= 7'd0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            loaded_q   <= loaded_d;
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.WE           = we_q;
    assign bus.WA           = wa_q;
    assign bus.WD           = wd_q;
    assign bus.cpu_hold     = busy_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.loaded_words = loaded_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed sessions with random payloads,
// expected memory writes / status derived from the byte stream itself.
module tb_instr_loader;

    logic clk;
    logic reset;

    instr_loader_if bus_if ();

    instr_loader #(.DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  pay_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];
    int          hold_bad  = 0;
    int          busy_drop = 0;
    bit          in_session = 1'b0;

    // Observe write port and hold/busy relationship away from the clock edge
    always @(posedge clk) begin
        #2;
        if (bus_if.WE === 1'b1) act_q.push_back({bus_if.WA, bus_if.WD});
        if (bus_if.busy !== bus_if.cpu_hold) hold_bad++;
        if (in_session && bus_if.busy !== 1'b1) busy_drop++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int wc);
        pay_q.delete();
        for (int i = 0; i < 4 * wc; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus_if.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        n = 0;
        while (bus_if.rx_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) begin
            checks++;
            errors++;
            $error("FAIL rx_ready_wait observed=timeout expected=ready");
        end
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'($urandom);
    endtask

    // Full session from pay_q; model packs bytes little-endian and XORs them
    task automatic run_session(input int wc, input bit bad_csum, input int maxgap,
                               input bit restart_pulse, input string tag);
        logic [7:0]  csum;
        logic [31:0] w;
        logic [7:0]  cb;
        int          n;
        exp_q.delete();
        act_q.delete();
        hold_bad  = 0;
        busy_drop = 0;
        csum = 8'h00;
        for (int i = 0; i < wc; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w[8*k +: 8] = pay_q[4*i + k];
                csum = csum ^ pay_q[4*i + k];
            end
            exp_q.push_back({32'(i * 4), w});
        end

        bus_if.start      = 1'b1;
        bus_if.word_count = 7'(wc);
        @(negedge clk);
        bus_if.start      = 1'b0;
        bus_if.word_count = 7'($urandom);
        in_session = 1'b1;
        check({tag, "_busy_start"}, 32'(bus_if.busy), 32'd1);
        check({tag, "_ready_start"}, 32'(bus_if.rx_ready), 32'd1);

        if (restart_pulse) begin
            bus_if.start      = 1'b1;
            bus_if.word_count = 7'(wc + 4);
            @(negedge clk);
            bus_if.start = 1'b0;
        end

        for (int i = 0; i < 4 * wc; i++)
            send_byte(pay_q[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        cb = bad_csum ? (csum ^ 8'h5A) : csum;
        send_byte(cb, 0);

        n = 0;
        while (bus_if.done !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(bus_if.done), 32'd1);
        in_session = 1'b0;
        check({tag, "_err"}, 32'(bus_if.err), 32'(bad_csum));
        check({tag, "_loaded"}, 32'(bus_if.loaded_words), 32'(wc));
        check({tag, "_we_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) begin
                check({tag, "_wa"}, act_q[i][63:32], exp_q[i][63:32]);
                check({tag, "_wd"}, act_q[i][31:0],  exp_q[i][31:0]);
            end
        end
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(bus_if.done), 32'd0);
        check({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_hold_end"}, 32'(bus_if.cpu_hold), 32'd0);
        check({tag, "_hold_tracks_busy"}, 32'(hold_bad), 32'd0);
        check({tag, "_busy_dropped"}, 32'(busy_drop), 32'd0);
        check({tag, "_wa_hold"}, bus_if.WA, exp_q[exp_q.size() - 1][63:32]);
    endtask

    task automatic bad_start(input int wc, input string tag);
        int n;
        act_q.delete();
        bus_if.start      = 1'b1;
        bus_if.word_count = 7'(wc);
        @(negedge clk);
        bus_if.start = 1'b0;
        n = 0;
        while (bus_if.done !== 1'b1 && n < 2) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(bus_if.done), 32'd1);
        check({tag, "_err"}, 32'(bus_if.err), 32'd1);
        @(negedge clk);
        check({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_done_one_cycle"}, 32'(bus_if.done), 32'd0);
        check({tag, "_err_hold"}, 32'(bus_if.err), 32'd1);
        check({tag, "_no_we"}, 32'(act_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(bus_if.rx_ready), 32'd0);
        check({tag, "_we"},       32'(bus_if.WE), 32'd0);
        check({tag, "_hold"},     32'(bus_if.cpu_hold), 32'd0);
        check({tag, "_busy"},     32'(bus_if.busy), 32'd0);
        check({tag, "_done"},     32'(bus_if.done), 32'd0);
        check({tag, "_err"},      32'(bus_if.err), 32'd0);
        check({tag, "_wa"},       bus_if.WA, 32'd0);
        check({tag, "_wd"},       bus_if.WD, 32'd0);
        check({tag, "_loaded"},   32'(bus_if.loaded_words), 32'd0);
    endtask

    initial begin
        bus_if.start      = 1'b0;
        bus_if.word_count = 7'd0;
        bus_if.rx_data    = 8'd0;
        bus_if.rx_valid   = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("por_no_autostart", 32'(bus_if.busy), 32'd0);

        // Known single-word image with correct checksum 0xA0
        pay_q.delete();
        pay_q.push_back(8'h0F);
        pay_q.push_back(8'h00);
        pay_q.push_back(8'h4F);
        pay_q.push_back(8'hE0);
        run_session(1, 1'b0, 0, 1'b0, "one_word");
        check("one_word_wd_value", bus_if.WD, 32'hE04F000F);

        fill_random(2);
        run_session(2, 1'b1, 2, 1'b0, "bad_csum");

        bad_start(0, "count0");
        bad_start(65, "count65");

        fill_random(64);
        run_session(64, 1'b0, 5, 1'b0, "full64");
        check("full64_last_wa", bus_if.WA, 32'd252);

        fill_random(3);
        run_session(3, 1'b0, 1, 1'b1, "restart_ignored");

        // Abort after two bytes of a one-word session
        fill_random(1);
        act_q.delete();
        bus_if.start      = 1'b1;
        bus_if.word_count = 7'd1;
        @(negedge clk);
        bus_if.start = 1'b0;
        send_byte(pay_q[0], 0);
        send_byte(pay_q[1], 0);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        check("mid_reset_no_we", 32'(act_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_reset_no_autostart", 32'(bus_if.busy), 32'd0);
        check("mid_reset_not_ready", 32'(bus_if.rx_ready), 32'd0);

        fill_random(1);
        run_session(1, 1'b0, 0, 1'b0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit instruction words in the target memory.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-005 SHALL have port word_count  input  7  number of words to load, sampled on the accepted start.
REQ-006 SHALL have port rx_data  input  8  incoming byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port WE  output  1  instruction-memory write enable.
REQ-010 SHALL have port WA  output  32  instruction-memory byte address, word aligned (WA[1:0]=0).
REQ-011 SHALL have port WD  output  32  instruction-memory write data.
REQ-012 SHALL have port cpu_hold  output  1  keeps the CPU stalled while loading.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  one-cycle end-of-session pulse.
REQ-015 SHALL have port err  output  1  last session failed (bad count or checksum).
REQ-016 SHALL have port loaded_words  output  7  words written in the current/last session.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE, CHECK, FINISH.
REQ-018 SHALL accept a byte only on a cycle with rx_valid=1 and rx_ready=1; rx_ready=1 only in RECV and CHECK.
REQ-019 IDLE: start=1 with 1<=word_count<=DEPTH -> RECV; clear err, loaded_words, byte index, word index, checksum.
REQ-020 IDLE: start=1 with word_count=0 or >DEPTH -> FINISH with err=1; no WE asserted.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 RECV: assemble little-endian; byte k (0..3) of a word lands in WD[8k+7:8k]; after the 4th accepted byte -> WRITE next cycle.
REQ-023 SHALL XOR every accepted data byte into an 8-bit running checksum.
REQ-024 WRITE: WE=1 for exactly one cycle, WA = word_index*4, WD = assembled word; loaded_words increments in the same cycle.
REQ-025 WRITE -> CHECK if the word just written is word word_count-1, else -> RECV with word_index+1.
REQ-026 CHECK: one accepted byte compared with the running checksum; mismatch sets err=1; then -> FINISH.
REQ-027 FINISH: done=1 for one cycle, then -> IDLE.
REQ-028 busy=1 and cpu_hold=1 in RECV, WRITE, CHECK, FINISH; both 0 in IDLE.
REQ-029 WE SHALL be 0 in every state except WRITE; WA/WD hold their last values when WE=0.
REQ-030 err and loaded_words SHALL hold their values in IDLE until the next accepted start.
REQ-031 Word address SHALL never exceed (DEPTH-1)*4; no wrap-around is possible because of REQ-020.
REQ-032 Stalls: rx_valid=0 for any number of cycles in RECV/CHECK leaves all state unchanged; no timeout.

Reset
REQ-033 reset=0 SHALL force IDLE immediately (asynchronously): rx_ready, WE, cpu_hold, busy, done, err = 0; WA, WD = 0; loaded_words = 0; internal indices and checksum = 0.
REQ-034 Reset mid-session SHALL discard any partially assembled word; words already written are not reverted.
REQ-035 Leaving reset (reset=1) SHALL NOT start a session without start.

Verification
REQ-036 start, word_count=1, bytes 0x0F,0x00,0x4F,0xE0, checksum 0xA0 -> one WE pulse, WA=0, WD=0xE04F000F, done pulse, err=0, loaded_words=1.
REQ-037 start, word_count=2, 8 bytes then wrong checksum byte -> WE pulses at WA=0 and WA=4, err=1, done pulse, loaded_words=2.
REQ-038 start, word_count=0 and separately word_count=65 -> no WE, done pulse within 2 cycles, err=1, busy back to 0.
REQ-039 rx_valid toggled randomly (gaps of 0-5 cycles) during a 64-word load -> 64 WE pulses, WA 0..252 step 4, last WA=252, cpu_hold high throughout, err=0.
REQ-040 reset=0 asserted after 2 bytes of word 1 -> all outputs at reset values same cycle; next full 1-word session writes WA=0 with only the new bytes.
REQ-041 start pulsed again during RECV -> ignored; session completes with original word_count.
